// File: rtl/fwd_rr_sched_pkg.sv
// Shared definitions for the forwarder round-robin scheduler: state encoding and tag sizing.
// The FWD_CLOG2 macro is here for files that need tag widths before the package is visible.
`ifndef FWD_CLOG2
`define FWD_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

package fwd_rr_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OFFER = 2'd1,
      ST_BUSY  = 2'd2
   } sched_state_e;

   // A tag must stay at least one bit wide, even for a degenerate single-core build.
   function automatic int clog2(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fwd_rr_sched_if.sv
// Bundle of the forwarder-side and core-side handshake signals around fwd_rr_sched.
// The slave modport belongs to the scheduler; the master modport belongs to the forwarder and cores.
interface fwd_rr_sched_if #(
   parameter int N                  = 4,
   parameter int PACKMEM_ADDR_WIDTH = 8,
   parameter int PACKMEM_DATA_WIDTH = 64,
   parameter int PLEN_WIDTH         = 32
);
   logic [PACKMEM_ADDR_WIDTH-1:0]   addr;
   logic                            rd_en;
   logic [PACKMEM_DATA_WIDTH-1:0]   rd_data;
   logic                            rd_data_vld;
   logic [PLEN_WIDTH-1:0]           byte_len;
   logic                            done;
   logic                            rdy;
   logic                            ack;
   logic [PACKMEM_ADDR_WIDTH-1:0]   fwd_addr;
   logic [N-1:0]                    fwd_rd_en;
   logic [N*PACKMEM_DATA_WIDTH-1:0] fwd_rd_data;
   logic [N-1:0]                    fwd_rd_data_vld;
   logic [N*PLEN_WIDTH-1:0]         fwd_byte_len;
   logic [N-1:0]                    fwd_done;
   logic [N-1:0]                    rdy_for_fwd;
   logic [N-1:0]                    rdy_for_fwd_ack;

   modport slave (
      input  addr, rd_en, done, ack,
      input  fwd_rd_data, fwd_rd_data_vld, fwd_byte_len, rdy_for_fwd,
      output rd_data, rd_data_vld, byte_len, rdy,
      output fwd_addr, fwd_rd_en, fwd_done, rdy_for_fwd_ack
   );

   modport master (
      output addr, rd_en, done, ack,
      output fwd_rd_data, fwd_rd_data_vld, fwd_byte_len, rdy_for_fwd,
      input  rd_data, rd_data_vld, byte_len, rdy,
      input  fwd_addr, fwd_rd_en, fwd_done, rdy_for_fwd_ack
   );
endinterface

// File: rtl/fwd_rr_sched_rr_pick.sv
// Rotating-priority encoder: first requester at or after ptr, wrapping N-1 -> 0.
// Purely combinational so it can also serve snoop-side arbitration.
module rr_pick
   import fwd_rr_sched_pkg::*;
#(
   parameter int N      = 4,
   parameter int TAG_SZ = 2
) (
   input  logic [N-1:0]      req,
   input  logic [TAG_SZ-1:0] ptr,
   output logic [TAG_SZ-1:0] gnt_tag,
   output logic              any
);
   logic [2*N-1:0] req_dbl;
   logic [N-1:0]   req_rot;
   logic [TAG_SZ:0] sum;
   logic            found;

   // Rotating the doubled vector puts the requester at ptr into bit 0.
   assign req_dbl = {req, req} >> ptr;
   assign req_rot = req_dbl[N-1:0];
   assign any     = |req;

   always_comb begin
      gnt_tag = '0;
      found   = 1'b0;
      sum     = '0;
      for (int i = 0; i < N; i++) begin
         if (!found && req_rot[i]) begin
            found = 1'b1;
            sum   = {1'b0, ptr} + (TAG_SZ+1)'(i);
            // Wrap by compare-and-subtract so non-power-of-two N never aliases.
            if (sum >= (TAG_SZ+1)'(N)) begin
               sum = sum - (TAG_SZ+1)'(N);
            end
            gnt_tag = sum[TAG_SZ-1:0];
         end
      end
   end
endmodule

// File: rtl/fwd_rr_sched.sv
// Round-robin scheduler sharing one forwarder among N packet filter cores.
// Define FWD_SCHED_STATS_EN to add the pkt_cnt / stall_cnt statistics outputs.
module fwd_rr_sched
   import fwd_rr_sched_pkg::*;
#(
   parameter int N                  = 4,
   parameter int TAG_SZ             = clog2(N),
   parameter int PACKMEM_ADDR_WIDTH = 8,
   parameter int PACKMEM_DATA_WIDTH = 64,
   parameter int PLEN_WIDTH         = 32
) (
   input  logic           clk,
   input  logic           rst,
   fwd_rr_sched_if.slave  bus
`ifdef FWD_SCHED_STATS_EN
   ,
   output logic [31:0]    pkt_cnt,
   output logic [31:0]    stall_cnt
`endif
);
   sched_state_e      state_q, state_d;
   logic [TAG_SZ-1:0] ptr_q, ptr_d;
   logic [TAG_SZ-1:0] tag_q, tag_d;
   logic              rdy_q, rdy_d;
   logic [TAG_SZ-1:0] pick_tag;
   logic              pick_any;
   logic [N-1:0]      tag_oh;
   logic              tag_req;
   logic              ack_fire;
   logic              done_fire;
   logic              rd_fire;

   logic [PACKMEM_DATA_WIDTH-1:0] data_arr [N];
   logic [PLEN_WIDTH-1:0]         len_arr  [N];

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_unpack
         assign data_arr[gi] = bus.fwd_rd_data[gi*PACKMEM_DATA_WIDTH +: PACKMEM_DATA_WIDTH];
         assign len_arr[gi]  = bus.fwd_byte_len[gi*PLEN_WIDTH +: PLEN_WIDTH];
      end
   endgenerate

   rr_pick #(
      .N      (N),
      .TAG_SZ (TAG_SZ)
   ) u_pick (
      .req     (bus.rdy_for_fwd),
      .ptr     (ptr_q),
      .gnt_tag (pick_tag),
      .any     (pick_any)
   );

   assign tag_oh  = N'(1) << tag_q;
   assign tag_req = bus.rdy_for_fwd[tag_q];

   // Pulses are suppressed while rst is high so a mid-packet reset emits no ack/done.
   assign ack_fire  = !rst && (state_q == ST_OFFER) && bus.ack && tag_req;
   assign done_fire = !rst && (state_q == ST_BUSY) && bus.done;
   assign rd_fire   = !rst && (state_q == ST_BUSY) && bus.rd_en;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      tag_d   = tag_q;
      rdy_d   = rdy_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               tag_d   = pick_tag;
               state_d = ST_OFFER;
               rdy_d   = 1'b1;
            end
         end
         ST_OFFER: begin
            // A core withdrawing its packet cancels the offer without touching ptr.
            if (!tag_req) begin
               state_d = ST_IDLE;
               rdy_d   = 1'b0;
            end else if (bus.ack) begin
               state_d = ST_BUSY;
               rdy_d   = 1'b0;
            end
         end
         ST_BUSY: begin
            if (bus.done) begin
               ptr_d   = (tag_q == TAG_SZ'(N-1)) ? '0 : tag_q + TAG_SZ'(1);
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            rdy_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         tag_q   <= '0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         tag_q   <= tag_d;
         rdy_q   <= rdy_d;
      end
   end

   // Read data follows tag_q in every state so late returns after done still reach the forwarder.
   assign bus.rdy             = rdy_q;
   assign bus.fwd_addr        = bus.addr;
   assign bus.byte_len        = (state_q == ST_IDLE) ? '0 : len_arr[tag_q];
   assign bus.rd_data         = data_arr[tag_q];
   assign bus.rd_data_vld     = !rst && bus.fwd_rd_data_vld[tag_q];
   assign bus.fwd_rd_en       = rd_fire   ? tag_oh : '0;
   assign bus.fwd_done        = done_fire ? tag_oh : '0;
   assign bus.rdy_for_fwd_ack = ack_fire  ? tag_oh : '0;

`ifdef FWD_SCHED_STATS_EN
   logic [31:0] pkt_cnt_q, pkt_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      pkt_cnt_d   = pkt_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (done_fire) begin
         pkt_cnt_d = pkt_cnt_q + 32'd1;
      end
      if ((state_q == ST_OFFER) && !bus.ack && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_cnt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         pkt_cnt_q   <= pkt_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign pkt_cnt   = pkt_cnt_q;
   assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_fwd_rr_sched.sv
// Directed bench for fwd_rr_sched with four cores; expected values are hand-derived per scenario.
module tb_fwd_rr_sched;
   localparam int N    = 4;
   localparam int PAW  = 8;
   localparam int PDW  = 64;
   localparam int PLEN = 32;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   fwd_rr_sched_if #(
      .N(N), .PACKMEM_ADDR_WIDTH(PAW), .PACKMEM_DATA_WIDTH(PDW), .PLEN_WIDTH(PLEN)
   ) bus ();

`ifdef FWD_SCHED_STATS_EN
   logic [31:0] pkt_cnt;
   logic [31:0] stall_cnt;
`endif

   fwd_rr_sched #(
      .N(N), .PACKMEM_ADDR_WIDTH(PAW), .PACKMEM_DATA_WIDTH(PDW), .PLEN_WIDTH(PLEN)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef FWD_SCHED_STATS_EN
      ,
      .pkt_cnt   (pkt_cnt),
      .stall_cnt (stall_cnt)
`endif
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rdy(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (bus.rdy === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.addr = '0; bus.rd_en = 1'b0; bus.done = 1'b0; bus.ack = 1'b0;
      bus.rdy_for_fwd = '0; bus.fwd_rd_data_vld = '0;
      bus.fwd_rd_data  = {64'hC0DE_0000_0000_0003, 64'hC0DE_0000_0000_0002,
                          64'hC0DE_0000_0000_0001, 64'hC0DE_0000_0000_0000};
      bus.fwd_byte_len = {32'd103, 32'd102, 32'd101, 32'd100};
      tick(); tick();
      rst = 1'b0;
      tick();
      #1;
      n_cmp++; if (bus.rdy !== 1'b0) begin n_err++; $display("FAIL reset_rdy: got %b want 0", bus.rdy); end
      n_cmp++; if (bus.byte_len !== 32'd0) begin n_err++; $display("FAIL reset_len: got %0d want 0", bus.byte_len); end
      n_cmp++; if (bus.fwd_done !== 4'b0000) begin n_err++; $display("FAIL reset_done: got %b want 0000", bus.fwd_done); end
      n_cmp++; if (bus.rdy_for_fwd_ack !== 4'b0000) begin n_err++; $display("FAIL reset_ack: got %b want 0000", bus.rdy_for_fwd_ack); end
      n_cmp++; if (bus.rd_data_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %b want 0", bus.rd_data_vld); end
      $display("reset: done");
   endtask

   task automatic test_single;
      bus.rdy_for_fwd = 4'b0100;
      #1;
      n_cmp++; if (bus.rdy !== 1'b0) begin n_err++; $display("FAIL single_rdy_c1: got %b want 0", bus.rdy); end
      tick();
      n_cmp++; if (bus.rdy !== 1'b1) begin n_err++; $display("FAIL single_rdy_c2: got %b want 1", bus.rdy); end
      n_cmp++; if (bus.byte_len !== 32'd102) begin n_err++; $display("FAIL single_len: got %0d want 102", bus.byte_len); end
      bus.ack = 1'b1;
      #1;
      n_cmp++; if (bus.rdy_for_fwd_ack !== 4'b0100) begin n_err++; $display("FAIL single_ack: got %b want 0100", bus.rdy_for_fwd_ack); end
      tick();
      bus.ack = 1'b0;
      #1;
      n_cmp++; if (bus.rdy !== 1'b0) begin n_err++; $display("FAIL single_busy_rdy: got %b want 0", bus.rdy); end
      n_cmp++; if (bus.rdy_for_fwd_ack !== 4'b0000) begin n_err++; $display("FAIL single_ack_clr: got %b want 0000", bus.rdy_for_fwd_ack); end
      bus.done = 1'b1;
      #1;
      n_cmp++; if (bus.fwd_done !== 4'b0100) begin n_err++; $display("FAIL single_done: got %b want 0100", bus.fwd_done); end
      tick();
      bus.done = 1'b0;
      bus.rdy_for_fwd = '0;
      $display("single: core2 offered, acked, done");
   endtask

   task automatic test_rr_order;
      bit       ok;
      int       exp_tag;
      logic [3:0] exp_oh;
      rst = 1'b1;
      bus.rdy_for_fwd = 4'b1111;
      tick();
      rst = 1'b0;
      for (int e = 0; e < 5; e++) begin
         exp_tag = e % 4;
         exp_oh  = 4'b0001 << exp_tag;
         wait_rdy(ok);
         n_cmp++; if (!ok) begin n_err++; $display("FAIL rr_wait%0d: got no rdy want rdy within 8 cycles", e); end
         n_cmp++; if (bus.byte_len !== 32'(100 + exp_tag)) begin n_err++; $display("FAIL rr_len%0d: got %0d want %0d", e, bus.byte_len, 100 + exp_tag); end
         bus.ack = 1'b1;
         #1;
         n_cmp++; if (bus.rdy_for_fwd_ack !== exp_oh) begin n_err++; $display("FAIL rr_ack%0d: got %b want %b", e, bus.rdy_for_fwd_ack, exp_oh); end
         tick();
         bus.ack  = 1'b0;
         bus.done = 1'b1;
         #1;
         n_cmp++; if (bus.fwd_done !== exp_oh) begin n_err++; $display("FAIL rr_done%0d: got %b want %b", e, bus.fwd_done, exp_oh); end
         tick();
         bus.done = 1'b0;
         $display("rr: grant %0d -> core %0d", e, exp_tag);
      end
`ifdef FWD_SCHED_STATS_EN
      n_cmp++; if (pkt_cnt !== 32'd5) begin n_err++; $display("FAIL rr_pkt_cnt: got %0d want 5", pkt_cnt); end
      n_cmp++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL rr_stall_cnt: got %0d want 0", stall_cnt); end
`endif
   endtask

   task automatic test_busy_read;
      bit ok;
      bus.rdy_for_fwd = 4'b0010;
      wait_rdy(ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL rd_wait: got no rdy want rdy within 8 cycles"); end
      n_cmp++; if (bus.byte_len !== 32'd101) begin n_err++; $display("FAIL rd_len: got %0d want 101", bus.byte_len); end
      bus.ack = 1'b1;
      tick();
      bus.ack = 1'b0;
      bus.addr = 8'd5;
      bus.rd_en = 1'b1;
      #1;
      n_cmp++; if (bus.fwd_rd_en !== 4'b0010) begin n_err++; $display("FAIL rd_strobe: got %b want 0010", bus.fwd_rd_en); end
      n_cmp++; if (bus.fwd_addr !== 8'd5) begin n_err++; $display("FAIL rd_addr: got %0d want 5", bus.fwd_addr); end
      bus.rd_en = 1'b0;
      bus.done = 1'b1;
      #1;
      n_cmp++; if (bus.fwd_done !== 4'b0010) begin n_err++; $display("FAIL rd_done: got %b want 0010", bus.fwd_done); end
      tick();
      bus.done = 1'b0;
      bus.rdy_for_fwd = '0;
      tick();
      bus.fwd_rd_data_vld = 4'b0010;
      bus.rd_en = 1'b1;
      #1;
      n_cmp++; if (bus.rd_data_vld !== 1'b1) begin n_err++; $display("FAIL rd_late_vld: got %b want 1", bus.rd_data_vld); end
      n_cmp++; if (bus.rd_data !== 64'hC0DE_0000_0000_0001) begin n_err++; $display("FAIL rd_late_data: got %h want c0de000000000001", bus.rd_data); end
      n_cmp++; if (bus.fwd_rd_en !== 4'b0000) begin n_err++; $display("FAIL rd_idle_strobe: got %b want 0000", bus.fwd_rd_en); end
      bus.fwd_rd_data_vld = '0;
      bus.rd_en = 1'b0;
      $display("busy_read: core1 addr 5, late data routed");
   endtask

   task automatic test_drop;
      bit ok;
      bus.rdy_for_fwd = 4'b1000;
      wait_rdy(ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL drop_wait: got no rdy want rdy within 8 cycles"); end
      n_cmp++; if (bus.byte_len !== 32'd103) begin n_err++; $display("FAIL drop_len3: got %0d want 103", bus.byte_len); end
      bus.rdy_for_fwd = 4'b0101;
      #1;
      n_cmp++; if (bus.rdy_for_fwd_ack !== 4'b0000) begin n_err++; $display("FAIL drop_noack: got %b want 0000", bus.rdy_for_fwd_ack); end
      tick();
      n_cmp++; if (bus.rdy !== 1'b0) begin n_err++; $display("FAIL drop_rdy_fall: got %b want 0", bus.rdy); end
      wait_rdy(ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL drop_rewait: got no rdy want rdy within 8 cycles"); end
      n_cmp++; if (bus.byte_len !== 32'd102) begin n_err++; $display("FAIL drop_repick: got len %0d want 102", bus.byte_len); end
      bus.ack = 1'b1;
      #1;
      n_cmp++; if (bus.rdy_for_fwd_ack !== 4'b0100) begin n_err++; $display("FAIL drop_ack2: got %b want 0100", bus.rdy_for_fwd_ack); end
      tick();
      bus.ack = 1'b0;
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      bus.rdy_for_fwd = '0;
      $display("drop: core3 withdrew, core2 picked from ptr");
   endtask

   task automatic test_spurious;
      bit ok;
      bus.ack = 1'b1; bus.done = 1'b1; bus.rd_en = 1'b1;
      #1;
      n_cmp++; if (bus.rdy_for_fwd_ack !== 4'b0000) begin n_err++; $display("FAIL spur_idle_ack: got %b want 0000", bus.rdy_for_fwd_ack); end
      n_cmp++; if (bus.fwd_done !== 4'b0000) begin n_err++; $display("FAIL spur_idle_done: got %b want 0000", bus.fwd_done); end
      n_cmp++; if (bus.fwd_rd_en !== 4'b0000) begin n_err++; $display("FAIL spur_idle_rd: got %b want 0000", bus.fwd_rd_en); end
      tick();
      bus.ack = 1'b0; bus.done = 1'b0; bus.rd_en = 1'b0;
      n_cmp++; if (bus.rdy !== 1'b0) begin n_err++; $display("FAIL spur_idle_rdy: got %b want 0", bus.rdy); end
      bus.rdy_for_fwd = 4'b0001;
      wait_rdy(ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL spur_wait: got no rdy want rdy within 8 cycles"); end
      bus.done = 1'b1; bus.rd_en = 1'b1;
      #1;
      n_cmp++; if (bus.fwd_done !== 4'b0000) begin n_err++; $display("FAIL spur_offer_done: got %b want 0000", bus.fwd_done); end
      n_cmp++; if (bus.fwd_rd_en !== 4'b0000) begin n_err++; $display("FAIL spur_offer_rd: got %b want 0000", bus.fwd_rd_en); end
      tick();
      bus.done = 1'b0; bus.rd_en = 1'b0;
      n_cmp++; if (bus.rdy !== 1'b1) begin n_err++; $display("FAIL spur_offer_hold: got %b want 1", bus.rdy); end
      n_cmp++; if (bus.byte_len !== 32'd100) begin n_err++; $display("FAIL spur_offer_len: got %0d want 100", bus.byte_len); end
      bus.ack = 1'b1;
      #1;
      n_cmp++; if (bus.rdy_for_fwd_ack !== 4'b0001) begin n_err++; $display("FAIL spur_ack0: got %b want 0001", bus.rdy_for_fwd_ack); end
      tick();
      bus.ack = 1'b0;
      $display("spurious: ack/done/rd_en ignored, core0 now busy");
   endtask

   task automatic test_reset_busy;
      bit ok;
      rst = 1'b1; bus.done = 1'b1; bus.rd_en = 1'b1;
      #1;
      n_cmp++; if (bus.fwd_done !== 4'b0000) begin n_err++; $display("FAIL rstb_done: got %b want 0000", bus.fwd_done); end
      n_cmp++; if (bus.fwd_rd_en !== 4'b0000) begin n_err++; $display("FAIL rstb_rd: got %b want 0000", bus.fwd_rd_en); end
      tick();
      rst = 1'b0; bus.done = 1'b0; bus.rd_en = 1'b0;
      bus.rdy_for_fwd = 4'b1001;
      #1;
      n_cmp++; if (bus.rdy !== 1'b0) begin n_err++; $display("FAIL rstb_rdy: got %b want 0", bus.rdy); end
`ifdef FWD_SCHED_STATS_EN
      n_cmp++; if (pkt_cnt !== 32'd0) begin n_err++; $display("FAIL rstb_pkt_cnt: got %0d want 0", pkt_cnt); end
`endif
      wait_rdy(ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL rstb_wait: got no rdy want rdy within 8 cycles"); end
      n_cmp++; if (bus.byte_len !== 32'd100) begin n_err++; $display("FAIL rstb_ptr0: got len %0d want 100", bus.byte_len); end
      bus.ack = 1'b1;
      #1;
      n_cmp++; if (bus.rdy_for_fwd_ack !== 4'b0001) begin n_err++; $display("FAIL rstb_ack: got %b want 0001", bus.rdy_for_fwd_ack); end
      tick();
      bus.ack = 1'b0; bus.done = 1'b1;
      tick();
      bus.done = 1'b0; bus.rdy_for_fwd = '0;
      $display("reset_busy: reset mid-packet, ptr restarted at core0");
   endtask

   initial begin
      test_reset();
      test_single();
      test_rr_order();
      test_busy_read();
      test_drop();
      test_spurious();
      test_reset_busy();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
